// File: rtl/edge_merge_pkg.sv
// Shared types and sizing helpers for the edge/color window merge stage.
package edge_merge_pkg;

    typedef enum logic {
        MODE_ALL = 1'b0,
        MODE_ANY = 1'b1
    } merge_mode_e;

    localparam int PIPE_LAT = 3;

    function automatic int sum_width(input int m);
        return $clog2(m * m + 1);
    endfunction

    function automatic int col_sum_width(input int m);
        return $clog2(m + 1);
    endfunction

    function automatic int center_of(input int m);
        return m / 2;
    endfunction

endpackage

// File: rtl/edge_color_window_stream_if.sv
// Pixel stream into the window merge stage and the gated result stream out of it.
interface edge_color_window_stream_if #(
    parameter int COLORS     = 2,
    parameter int EDGE_WIDTH = 1
);
    logic                  in_valid;
    logic                  in_sof;
    logic [COLORS:0]       in_color;
    logic [EDGE_WIDTH-1:0] in_edge;
    logic                  out_valid;
    logic [EDGE_WIDTH-1:0] out_edge;
    logic [COLORS-1:0]     out_hit;

    modport master (
        output in_valid, in_sof, in_color, in_edge,
        input  out_valid, out_edge, out_hit
    );

    modport slave (
        input  in_valid, in_sof, in_color, in_edge,
        output out_valid, out_edge, out_hit
    );
endinterface

// File: rtl/mask_line_buffer.sv
// One raster line of mask entries: asynchronous read, write on clock, so a read returns the old entry.
module mask_line_buffer #(
    parameter int  DEPTH = 640,
    parameter int  WIDTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wr_data;
    end
endmodule

// File: rtl/edge_color_window_stream.sv
// Streaming edge/color merge: line-buffered MxM colour-hit counts per colour gate the centre pixel's edge.
module edge_color_window_stream
    import edge_merge_pkg::*;
#(
    parameter int  M_SIZE     = 11,
    parameter int  COLORS     = 2,
    parameter int  EDGE_WIDTH = 1,
    parameter int  IMG_WIDTH  = 640,
    parameter int  IMG_HEIGHT = 480,
    localparam int SUM_WIDTH  = sum_width(M_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    edge_color_window_stream_if.slave   px,
    input  logic [COLORS*SUM_WIDTH-1:0] cfg_threshold,
    input  logic                        cfg_mode
);
    localparam int CENTER = center_of(M_SIZE);
    localparam int CS_W   = col_sum_width(M_SIZE);
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(IMG_HEIGHT);
    localparam int ENT_W  = EDGE_WIDTH + COLORS + 1;

    function automatic logic [SUM_WIDTH-1:0] widen(input logic [CS_W-1:0] v);
        return {{(SUM_WIDTH-CS_W){1'b0}}, v};
    endfunction

    function automatic logic at_threshold(input logic [SUM_WIDTH-1:0] sum,
                                          input logic [SUM_WIDTH-1:0] thr);
        return sum >= thr;
    endfunction

    function automatic logic gate_open(input logic [COLORS-1:0] hit, input merge_mode_e mode);
        return (mode == MODE_ANY) ? |hit : &hit;
    endfunction

    logic             accept;
    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;

    assign accept  = px.in_valid & ~reset;
    assign cur_col = px.in_sof ? '0 : col;
    assign cur_row = px.in_sof ? '0 : row;

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (cur_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // Buffer k holds the line k+1 rows above; each one feeds the next as it is overwritten.
    logic [ENT_W-1:0] lb_wr [M_SIZE-1];
    logic [ENT_W-1:0] lb_rd [M_SIZE-1];

    assign lb_wr[0] = {px.in_edge, px.in_color};

    for (genvar k = 0; k < M_SIZE - 1; k++) begin : g_lb
        if (k > 0) begin : g_casc
            assign lb_wr[k] = lb_rd[k-1];
        end
        mask_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(ENT_W)) u_lb (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (cur_col),
            .wr_data (lb_wr[k]),
            .rd_data (lb_rd[k])
        );
    end

    logic unused_last_edge;
    assign unused_last_edge = ^lb_rd[M_SIZE-2][ENT_W-1 -: EDGE_WIDTH];

    logic [CS_W-1:0]       col_sum [COLORS];
    logic [EDGE_WIDTH-1:0] center_rd;

    assign center_rd = lb_rd[CENTER-1][ENT_W-1 -: EDGE_WIDTH];

    always_comb begin
        for (int c = 0; c < COLORS; c++) begin
            col_sum[c] = CS_W'(px.in_color[COLORS] & px.in_color[c]);
            for (int k = 1; k < M_SIZE; k++) begin
                if (int'(cur_row) >= k)
                    col_sum[c] = col_sum[c] + CS_W'(lb_rd[k-1][COLORS] & lb_rd[k-1][c]);
            end
        end
    end

    // ---- S1: column sums and centre-edge read ----
    logic                  vld_p0, first_p0, outside_p0;
    logic [CS_W-1:0]       col_sum_p0 [COLORS];
    logic [EDGE_WIDTH-1:0] edge_ctr_p0;
    logic [EDGE_WIDTH-1:0] edge_hist [CENTER];

    always_ff @(posedge clk) begin
        if (reset) vld_p0 <= 1'b0;
        else       vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            col_sum_p0   <= col_sum;
            first_p0     <= (cur_col == '0);
            outside_p0   <= (int'(cur_row) < CENTER) || (int'(cur_col) < CENTER);
            edge_ctr_p0  <= edge_hist[CENTER-1];
            edge_hist[0] <= center_rd;
            for (int i = 1; i < CENTER; i++) edge_hist[i] <= edge_hist[i-1];
        end
    end

    // ---- S2: sliding window sum ----
    logic                  vld_p1, outside_p1;
    logic [EDGE_WIDTH-1:0] edge_ctr_p1;
    logic [SUM_WIDTH-1:0]  win_sum_p1 [COLORS];
    logic [CS_W-1:0]       win_hist [COLORS][M_SIZE];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            for (int c = 0; c < COLORS; c++) begin
                win_sum_p1[c] <= '0;
                for (int i = 0; i < M_SIZE; i++) win_hist[c][i] <= '0;
            end
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                for (int c = 0; c < COLORS; c++) begin
                    win_hist[c][0] <= col_sum_p0[c];
                    for (int i = 1; i < M_SIZE; i++)
                        win_hist[c][i] <= first_p0 ? '0 : win_hist[c][i-1];
                    win_sum_p1[c] <= first_p0 ? widen(col_sum_p0[c])
                                   : win_sum_p1[c] + widen(col_sum_p0[c]) - widen(win_hist[c][M_SIZE-1]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            outside_p1  <= outside_p0;
            edge_ctr_p1 <= edge_ctr_p0;
        end
    end

    logic [COLORS-1:0]     hit_c;
    logic [EDGE_WIDTH-1:0] edge_gated;

    always_comb begin
        for (int c = 0; c < COLORS; c++)
            hit_c[c] = ~outside_p1 & at_threshold(win_sum_p1[c], cfg_threshold[c*SUM_WIDTH +: SUM_WIDTH]);
        edge_gated = gate_open(hit_c, merge_mode_e'(cfg_mode)) ? edge_ctr_p1 : '0;
    end

    // ---- S3: compare, gate, registered outputs ----
    logic                  vld_p2;
    logic [COLORS-1:0]     hit_p2;
    logic [EDGE_WIDTH-1:0] edge_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2  <= 1'b0;
            hit_p2  <= '0;
            edge_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                hit_p2  <= hit_c;
                edge_p2 <= edge_gated;
            end
        end
    end

    assign px.out_valid = vld_p2;
    assign px.out_hit   = hit_p2;
    assign px.out_edge  = edge_p2;
endmodule

// File: tb/tb_edge_color_window_stream.sv
// Directed bench for edge_color_window_stream on a 3x3 window over an 8x6 frame.
module tb_edge_color_window_stream;
    localparam int M = 3, W = 8, H = 6, NT = 4096;

    logic       clk;
    logic       reset;
    logic [7:0] cfg_threshold;
    logic       cfg_mode;

    edge_color_window_stream_if #(.COLORS(2), .EDGE_WIDTH(1)) bus ();

    edge_color_window_stream #(
        .M_SIZE(M), .COLORS(2), .EDGE_WIDTH(1), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .px            (bus.slave),
        .cfg_threshold (cfg_threshold),
        .cfg_mode      (cfg_mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_vec = 0;
    int         n_err = 0;
    int         tk    = 0;
    logic       obs_v [NT];
    logic       obs_e [NT];
    logic [1:0] obs_h [NT];
    logic [2:0] fc    [H][W];
    logic       fe    [H][W];
    int         pt    [H][W];
    logic [2:0] ref_g [H][W];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v, input logic s, input logic r, input logic [2:0] col, input logic e);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_color = col;
        bus.in_edge  = e;
        reset        = r;
        @(posedge clk);
        @(negedge clk);
        obs_v[tk] = bus.out_valid;
        obs_e[tk] = bus.out_edge;
        obs_h[tk] = bus.out_hit;
        tk++;
    endtask

    task automatic fill_const(input logic [2:0] col, input logic e);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fc[r][c] = col;
                fe[r][c] = e;
            end
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fc[r][c] = {((r + c) % 4) != 3, ((c + 2 * r) % 3) != 0, ((c + r * r) % 2) == 0};
                fe[r][c] = ((3 * r + c) % 2) == 1;
            end
    endtask

    // Sends the frame in raster order, stopping before (stop_r, stop_c) when that lies inside it.
    task automatic send_frame(input int gap_pct, input int stop_r, input int stop_c);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                for (int g = 0; g < 4 && $urandom_range(0, 99) < gap_pct; g++) tick(0, 0, 0, 3'b000, 0);
                pt[r][c] = tk;
                tick(1, (r == 0 && c == 0), 0, fc[r][c], fe[r][c]);
            end
        repeat (3) tick(0, 0, 0, 3'b000, 0);
    endtask

    // Direct 3x3 summation over the stored frame; pixels outside the frame count as invalid.
    function automatic logic [2:0] model(input int r, input int c);
        int   s0, s1;
        logic h0, h1, g;
        if (r < 1 || c < 1) return 3'b000;
        s0 = 0;
        s1 = 0;
        for (int dr = 0; dr < M; dr++)
            for (int dc = 0; dc < M; dc++)
                if (r - dr >= 0 && c - dc >= 0 && fc[r-dr][c-dc][2]) begin
                    s0 += int'(fc[r-dr][c-dc][0]);
                    s1 += int'(fc[r-dr][c-dc][1]);
                end
        h0 = s0 >= int'(cfg_threshold[3:0]);
        h1 = s1 >= int'(cfg_threshold[7:4]);
        g  = cfg_mode ? (h0 | h1) : (h0 & h1);
        return {g & fe[r-1][c-1], h1, h0};
    endfunction

    function automatic logic [2:0] obs_at(input int r, input int c);
        return {obs_e[pt[r][c] + 2], obs_h[pt[r][c] + 2]};
    endfunction

    task automatic check_frame(input string name);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                check_val($sformatf("%s_vld(%0d,%0d)", name, r, c), obs_v[pt[r][c] + 2], 1);
                check_val($sformatf("%s_out(%0d,%0d)", name, r, c), obs_at(r, c), model(r, c));
            end
    endtask

    int s0, cnt;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_color  = '0;
        bus.in_edge   = '0;
        reset         = 1'b1;
        cfg_threshold = {4'd2, 4'd2};
        cfg_mode      = 1'b0;

        // reset held two cycles with pixels offered
        for (int i = 0; i < 2; i++) begin
            tick(1, 1, 1, 3'b111, 1);
            check_val($sformatf("rst_out%0d", i), {obs_v[tk-1], obs_e[tk-1], obs_h[tk-1]}, 4'b0000);
        end

        // uniform frame, mode ALL
        fill_const(3'b111, 1'b1);
        send_frame(0, -1, -1);
        check_val("first_lat0", obs_v[pt[0][0]], 0);
        check_val("first_lat1", obs_v[pt[0][0] + 1], 0);
        check_val("uni_2_2", obs_at(2, 2), 3'b111);
        check_val("uni_1_1", obs_at(1, 1), 3'b111);
        check_val("uni_0_5", obs_at(0, 5), 3'b000);
        check_frame("uni");

        // mask-valid bit low everywhere
        fill_const(3'b011, 1'b1);
        send_frame(0, -1, -1);
        check_val("vlow_3_3", obs_at(3, 3), 3'b000);
        check_frame("vlow");

        // colour 0 only, ALL then ANY
        fill_const(3'b101, 1'b1);
        send_frame(0, -1, -1);
        check_val("c0_all_3_3", obs_at(3, 3), 3'b001);
        check_frame("c0_all");
        cfg_mode = 1'b1;
        send_frame(0, -1, -1);
        check_val("c0_any_3_3", obs_at(3, 3), 3'b101);
        check_frame("c0_any");

        // single valid pixel, threshold 0 on colour 1
        cfg_mode      = 1'b0;
        cfg_threshold = {4'd0, 4'd1};
        fill_const(3'b000, 1'b1);
        fc[2][2] = 3'b101;
        send_frame(0, -1, -1);
        check_val("sparse_3_3", obs_at(3, 3), 3'b111);
        check_frame("sparse");

        // patterned frame, gapless then with gaps
        cfg_threshold = {4'd2, 4'd2};
        fill_pattern();
        send_frame(0, -1, -1);
        check_frame("pat");
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) ref_g[r][c] = obs_at(r, c);
        s0 = tk;
        send_frame(50, -1, -1);
        cnt = 0;
        for (int t = s0; t < tk; t++) cnt += int'(obs_v[t]);
        check_val("gap_count", cnt, H * W);
        check_frame("gap");
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                check_val($sformatf("gap_vs_gapless(%0d,%0d)", r, c), obs_at(r, c), ref_g[r][c]);

        // reset in the middle of a uniform frame, then a fresh patterned frame
        fill_const(3'b111, 1'b1);
        send_frame(0, 3, 4);
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 1, 3'b111, 1);
            check_val($sformatf("midrst_out%0d", i), {obs_v[tk-1], obs_e[tk-1], obs_h[tk-1]}, 4'b0000);
        end
        fill_pattern();
        send_frame(0, -1, -1);
        check_frame("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
